// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared widths, types and constants for the register file slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int ADDR_BITS = 5;
    localparam int NUM_REGS  = 2 ** ADDR_BITS;
    localparam int DATA_BITS = 32;

    typedef logic [ADDR_BITS-1:0] reg_addr_t;
    typedef logic [DATA_BITS-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard_busy_tracker.sv
// ============================================================================
// Module  : busy_tracker
// Brief   : Per-register pending bits, reservation handshake and busy lookups.
//           Optional macro REGFILE_WB_BYPASS_EN forwards same-cycle clears.
// Revision: 1.0
// ============================================================================
`default_nettype none

module busy_tracker
    import regfile_pkg::*;
#(
    parameter int ADDR_BITS_P = ADDR_BITS,
    parameter int NUM_REGS_P  = NUM_REGS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_rsv_valid,
    input  logic [ADDR_BITS_P-1:0] i_rsv_addr,
    output logic                   o_rsv_ready,
    input  logic                   i_wr_fire,
    input  logic [ADDR_BITS_P-1:0] i_wr_addr,
    input  logic [ADDR_BITS_P-1:0] i_rs1_addr,
    input  logic [ADDR_BITS_P-1:0] i_rs2_addr,
    output logic                   o_rs1_busy,
    output logic                   o_rs2_busy,
    output logic [NUM_REGS_P-1:0]  o_busy_mask
);

    logic [NUM_REGS_P-1:0] r_busy;
    logic [NUM_REGS_P-1:0] w_set;
    logic [NUM_REGS_P-1:0] w_clr;
    logic [NUM_REGS_P-1:0] w_busy_next;
    logic                  w_rsv_fire;
    logic                  w_rs1_fwd;
    logic                  w_rs2_fwd;
    logic                  w_rsv_fwd;

`ifdef REGFILE_WB_BYPASS_EN
    assign w_rs1_fwd = i_wr_fire && (i_wr_addr == i_rs1_addr);
    assign w_rs2_fwd = i_wr_fire && (i_wr_addr == i_rs2_addr);
    assign w_rsv_fwd = i_wr_fire && (i_wr_addr == i_rsv_addr);
`else
    assign w_rs1_fwd = 1'b0;
    assign w_rs2_fwd = 1'b0;
    assign w_rsv_fwd = 1'b0;
`endif

    // x0 has no busy bit in practice (bit 0 held low), so it is always ready.
    assign o_rsv_ready = !r_busy[i_rsv_addr] || w_rsv_fwd;
    assign w_rsv_fire  = i_rsv_valid && o_rsv_ready;

    assign o_rs1_busy  = r_busy[i_rs1_addr] && !w_rs1_fwd;
    assign o_rs2_busy  = r_busy[i_rs2_addr] && !w_rs2_fwd;
    assign o_busy_mask = r_busy;

    // Set wins over clear so a same-address reserve+write leaves the entry busy.
    assign w_set       = w_rsv_fire ? (NUM_REGS_P'(1) << i_rsv_addr) : '0;
    assign w_clr       = i_wr_fire  ? (NUM_REGS_P'(1) << i_wr_addr)  : '0;
    assign w_busy_next = ((r_busy & ~w_clr) | w_set) & ~NUM_REGS_P'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module  : regfile_scoreboard
// Brief   : 32-entry register file, two async reads, handshaked write-back and
//           issue-side busy scoreboard. Macro REGFILE_WB_BYPASS_EN enables
//           same-cycle write-to-read forwarding.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_BITS = regfile_pkg::DATA_BITS,
    parameter int NUM_REGS  = regfile_pkg::NUM_REGS,
    parameter int ADDR_BITS = regfile_pkg::ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_BITS-1:0] rs1_addr,
    output logic [DATA_BITS-1:0] rs1_data,
    output logic                 rs1_busy,
    input  logic [ADDR_BITS-1:0] rs2_addr,
    output logic [DATA_BITS-1:0] rs2_data,
    output logic                 rs2_busy,
    input  logic                 rsv_valid,
    input  logic [ADDR_BITS-1:0] rsv_addr,
    output logic                 rsv_ready,
    input  logic                 wr_valid,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_ready,
    output logic [NUM_REGS-1:0]  busy_mask
);

    logic [DATA_BITS-1:0] r_regs [NUM_REGS];
    logic                 w_wr_fire;
    logic [DATA_BITS-1:0] w_rs1_arr;
    logic [DATA_BITS-1:0] w_rs2_arr;

    // Holding ready low under reset guarantees nothing lands during reset.
    assign wr_ready  = reset_n;
    assign w_wr_fire = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_fire && (wr_addr != ZERO_REG)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    assign w_rs1_arr = (rs1_addr == ZERO_REG) ? '0 : r_regs[rs1_addr];
    assign w_rs2_arr = (rs2_addr == ZERO_REG) ? '0 : r_regs[rs2_addr];

`ifdef REGFILE_WB_BYPASS_EN
    assign rs1_data = (w_wr_fire && (wr_addr == rs1_addr) && (rs1_addr != ZERO_REG))
                      ? wr_data : w_rs1_arr;
    assign rs2_data = (w_wr_fire && (wr_addr == rs2_addr) && (rs2_addr != ZERO_REG))
                      ? wr_data : w_rs2_arr;
`else
    assign rs1_data = w_rs1_arr;
    assign rs2_data = w_rs2_arr;
`endif

    busy_tracker #(
        .ADDR_BITS_P (ADDR_BITS),
        .NUM_REGS_P  (NUM_REGS)
    ) u_busy_tracker (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_rsv_valid (rsv_valid),
        .i_rsv_addr  (rsv_addr),
        .o_rsv_ready (rsv_ready),
        .i_wr_fire   (w_wr_fire),
        .i_wr_addr   (wr_addr),
        .i_rs1_addr  (rs1_addr),
        .i_rs2_addr  (rs2_addr),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy),
        .o_busy_mask (busy_mask)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module  : tb_regfile_scoreboard
// Brief   : Directed self-checking bench for regfile_scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    logic        clk;
    logic        reset_n;
    logic [4:0]  rs1_addr, rs2_addr, rsv_addr, wr_addr;
    logic [31:0] rs1_data, rs2_data, wr_data;
    logic        rs1_busy, rs2_busy, rsv_valid, rsv_ready, wr_valid, wr_ready;
    logic [31:0] busy_mask;

    int total;
    int bad;

    regfile_scoreboard dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rs1_addr  (rs1_addr),
        .rs1_data  (rs1_data),
        .rs1_busy  (rs1_busy),
        .rs2_addr  (rs2_addr),
        .rs2_data  (rs2_data),
        .rs2_busy  (rs2_busy),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .busy_mask (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        settle();
        total++;
        if (wr_ready !== 1'b0) begin
            bad++; $display("FAIL reset_wr_ready_low got=%0b exp=0", wr_ready);
        end
        tick(); tick();
        reset_n  = 1'b1;
        rs1_addr = 5'd5;
        rs2_addr = 5'd31;
        settle();
        total++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            bad++; $display("FAIL reset_read got=%h/%h exp=0/0", rs1_data, rs2_data);
        end
        total++;
        if (busy_mask !== 32'h0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%h exp=0", busy_mask);
        end
        total++;
        if (wr_ready !== 1'b1) begin
            bad++; $display("FAIL reset_wr_ready got=%0b exp=1", wr_ready);
        end
    endtask

    task automatic test_write_read();
        tick();
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        tick();
        wr_valid = 1'b0; rs1_addr = 5'd7;
        settle();
        total++;
        if (rs1_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL write_x7 got=%h exp=deadbeef", rs1_data);
        end
        tick();
        wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        settle();
        total++;
        if (wr_ready !== 1'b1) begin
            bad++; $display("FAIL write_x0_ready got=%0b exp=1", wr_ready);
        end
        tick();
        wr_valid = 1'b0; rs2_addr = 5'd0;
        settle();
        total++;
        if (rs2_data !== 32'h0 || busy_mask !== 32'h0) begin
            bad++; $display("FAIL write_x0 got=%h mask=%h exp=0", rs2_data, busy_mask);
        end
    endtask

    task automatic test_reserve();
        tick();
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        settle();
        total++;
        if (rsv_ready !== 1'b1) begin
            bad++; $display("FAIL rsv_x3_ready got=%0b exp=1", rsv_ready);
        end
        tick();
        rs1_addr = 5'd3;
        settle();
        total++;
        if (busy_mask !== 32'h8 || rs1_busy !== 1'b1) begin
            bad++; $display("FAIL rsv_x3_busy got=%h/%0b exp=00000008/1", busy_mask, rs1_busy);
        end
        total++;
        if (rsv_ready !== 1'b0) begin
            bad++; $display("FAIL rsv_x3_stall got=%0b exp=0", rsv_ready);
        end
        tick();
        rsv_valid = 1'b0;
        wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5;
        tick();
        wr_valid = 1'b0;
        settle();
        total++;
        if (busy_mask !== 32'h0 || rs1_busy !== 1'b0 || rs1_data !== 32'hA5) begin
            bad++; $display("FAIL rsv_x3_clear got=%h/%0b/%h exp=0/0/a5", busy_mask, rs1_busy, rs1_data);
        end
        tick();
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        settle();
        total++;
        if (rsv_ready !== 1'b1) begin
            bad++; $display("FAIL rsv_x0_ready got=%0b exp=1", rsv_ready);
        end
        tick();
        rsv_valid = 1'b0;
        settle();
        total++;
        if (busy_mask !== 32'h0) begin
            bad++; $display("FAIL rsv_x0_mask got=%h exp=0", busy_mask);
        end
    endtask

    task automatic test_same_addr();
        tick();
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        tick();
        rsv_valid = 1'b0; wr_valid = 1'b0; rs2_addr = 5'd9;
        settle();
        total++;
        if (rs2_data !== 32'h55 || busy_mask !== 32'h200 || rs2_busy !== 1'b1) begin
            bad++; $display("FAIL same_free got=%h/%h exp=55/00000200", rs2_data, busy_mask);
        end
        // x9 now busy: repeat the simultaneous request.
        tick();
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h66;
        settle();
`ifdef REGFILE_WB_BYPASS_EN
        total++;
        if (rsv_ready !== 1'b1) begin
            bad++; $display("FAIL same_busy_ready got=%0b exp=1", rsv_ready);
        end
        tick();
        rsv_valid = 1'b0; wr_valid = 1'b0;
        settle();
        total++;
        if (busy_mask !== 32'h200 || rs2_data !== 32'h66) begin
            bad++; $display("FAIL same_busy_both got=%h/%h exp=00000200/66", busy_mask, rs2_data);
        end
`else
        total++;
        if (rsv_ready !== 1'b0) begin
            bad++; $display("FAIL same_busy_ready got=%0b exp=0", rsv_ready);
        end
        tick();
        wr_valid = 1'b0;
        settle();
        total++;
        if (busy_mask !== 32'h0 || rs2_data !== 32'h66 || rsv_ready !== 1'b1) begin
            bad++; $display("FAIL same_busy_wr got=%h/%h/%0b exp=0/66/1", busy_mask, rs2_data, rsv_ready);
        end
        tick();
        rsv_valid = 1'b0;
        settle();
        total++;
        if (busy_mask !== 32'h200) begin
            bad++; $display("FAIL same_busy_rsv got=%h exp=00000200", busy_mask);
        end
`endif
        tick();
        wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h66;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_same_cycle_read();
        rsv_valid = 1'b1; rsv_addr = 5'd12;
        tick();
        rsv_valid = 1'b0;
        wr_valid = 1'b1; wr_addr = 5'd12; wr_data = 32'h77; rs1_addr = 5'd12;
        settle();
`ifdef REGFILE_WB_BYPASS_EN
        total++;
        if (rs1_data !== 32'h77 || rs1_busy !== 1'b0) begin
            bad++; $display("FAIL same_cycle_read got=%h/%0b exp=77/0", rs1_data, rs1_busy);
        end
`else
        total++;
        if (rs1_data !== 32'h0 || rs1_busy !== 1'b1) begin
            bad++; $display("FAIL same_cycle_read got=%h/%0b exp=0/1", rs1_data, rs1_busy);
        end
`endif
        tick();
        wr_valid = 1'b0;
        settle();
        total++;
        if (rs1_data !== 32'h77 || rs1_busy !== 1'b0 || busy_mask !== 32'h0) begin
            bad++; $display("FAIL next_cycle_read got=%h/%0b/%h exp=77/0/0", rs1_data, rs1_busy, busy_mask);
        end
    endtask

    task automatic test_diff_addr();
        tick();
        rsv_valid = 1'b1; rsv_addr = 5'd20;
        wr_valid = 1'b1; wr_addr = 5'd21; wr_data = 32'h1111;
        tick();
        rsv_valid = 1'b0; wr_valid = 1'b0;
        rs1_addr = 5'd20; rs2_addr = 5'd21;
        settle();
        total++;
        if (busy_mask !== 32'h0010_0000 || rs1_busy !== 1'b1 || rs2_busy !== 1'b0 || rs2_data !== 32'h1111) begin
            bad++; $display("FAIL diff_addr got=%h/%0b/%0b/%h exp=00100000/1/0/1111",
                            busy_mask, rs1_busy, rs2_busy, rs2_data);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        reset_n = 1'b0;
        wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 32'hFF;
        settle();
        total++;
        if (wr_ready !== 1'b0) begin
            bad++; $display("FAIL mid_reset_ready got=%0b exp=0", wr_ready);
        end
        tick(); tick();
        reset_n = 1'b1; wr_valid = 1'b0;
        rs1_addr = 5'd4; rs2_addr = 5'd7;
        settle();
        total++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || busy_mask !== 32'h0) begin
            bad++; $display("FAIL mid_reset got=%h/%h/%h exp=0/0/0", rs1_data, rs2_data, busy_mask);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0;
        rs1_addr = '0; rs2_addr = '0; rsv_addr = '0; wr_addr = '0;
        rsv_valid = 1'b0; wr_valid = 1'b0; wr_data = '0;
        #1;
        test_reset();
        test_write_read();
        test_reserve();
        test_same_addr();
        test_same_cycle_read();
        test_diff_addr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 32-entry integer register file with an issue-side busy scoreboard. It is the storage that the read-select mux tree reads from and that the write-steer demux writes into.
- Two asynchronous read ports.
- One write-back port with a valid/ready handshake.
- One reservation port that issue logic uses to mark a destination register pending, which gives RAW/WAW hazard visibility.
- Sits between decode/issue and the execute/write-back stages of the core.

Parameters:
- DATA_BITS, 32, register width.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_BITS.
- ADDR_BITS, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous reset, active-low
- rs1_addr  in  ADDR_BITS  read port 1 index
- rs1_data  out  DATA_BITS  read port 1 data
- rs1_busy  out  1  rs1 register has a pending reservation
- rs2_addr  in  ADDR_BITS  read port 2 index
- rs2_data  out  DATA_BITS  read port 2 data
- rs2_busy  out  1  rs2 register has a pending reservation
- rsv_valid  in  1  issue requests reservation of rsv_addr
- rsv_addr  in  ADDR_BITS  destination to reserve
- rsv_ready  out  1  reservation can be accepted this cycle
- wr_valid  in  1  write-back request
- wr_addr  in  ADDR_BITS  write-back destination
- wr_data  in  DATA_BITS  write-back data
- wr_ready  out  1  write port accepts
- busy_mask  out  NUM_REGS  registered busy bit vector; bit 0 is always 0

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, reset_n.
- Reset (reset_n low at a clk edge):
  - all registers cleared to 0 and busy_mask cleared to 0.
  - wr_ready is 0 while reset_n is low and 1 otherwise.
  - rs1_data/rs2_data read 0 on the cycle after reset; rs*_busy read 0.
  - Reset asserted mid-operation discards any in-flight handshake; no write lands in that cycle.
- Reads:
  - combinational, zero latency: rsN_data = regs[rsN_addr] and rsN_busy = busy[rsN_addr].
  - Register x0 always reads 0 and is never busy.
- Write-back fire = wr_valid & wr_ready:
  - regs[wr_addr] <= wr_data and busy[wr_addr] <= 0 at the next edge.
  - wr_addr == 0: no state changes, but the handshake still completes.
  - Writing to a non-busy register is legal.
- Reservation fire = rsv_valid & rsv_ready:
  - busy[rsv_addr] <= 1 at the next edge.
  - rsv_ready = !busy[rsv_addr], evaluated combinationally on the current busy state, so WAW reservations stall.
  - rsv_addr == 0: rsv_ready = 1 and the request has no effect.
- Simultaneous fire, same nonzero address:
  - Address already busy: rsv_ready = 0, so only the write fires. Busy clears, and the reservation is accepted on the following cycle.
  - Address not busy: both fire. Data is stored and busy ends at 1; the reservation wins.
- Simultaneous fire, different addresses: the two are independent.
- Read on the same cycle as a write to that address, without the optional feature: returns the old value and old busy; the new value is visible the next cycle.
- Busy state is held in a sequential update only: no combinational path from rsv_valid or wr_valid to busy_mask.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: when write fire and wr_addr == rsN_addr != 0, rsN_data = wr_data and rsN_busy = 0 in the same cycle.
  - rsv_ready for rsv_addr == wr_addr also uses the post-write busy value, i.e. it is 1 when a write to that address fires.
  - The same-address, already-busy case therefore accepts both fires in one cycle, and busy ends at 1.
- Not defined: behaviour exactly as in Behaviour; no bypass logic is synthesised.

Decomposition:
- Package regfile_pkg holds:
  - localparams ADDR_BITS, NUM_REGS, DATA_BITS
  - typedef reg_addr_t (logic [ADDR_BITS-1:0])
  - typedef reg_data_t (logic [DATA_BITS-1:0])
  - constant ZERO_REG = '0
- One sub-module, busy_tracker: owns the busy_mask register, set/clear priority, the x0 masking and the rsv_ready generation.
- The data array stays in the top module.

Test Plan:
- Reset then read: pulse reset_n low 2 cycles, read rs1_addr=5, rs2_addr=31 -> rs1_data=0, rs2_data=0, busy_mask=0, wr_ready=1.
- Write then read: write x7=0xDEADBEEF -> next cycle rs1_addr=7 gives 0xDEADBEEF. Write x0=0x1234 -> rs2_addr=0 gives 0.
- Reserve, stall, clear:
  - reserve x3 -> busy_mask[3]=1, rs1_busy=1 for rs1_addr=3.
  - reserve x3 again -> rsv_ready=0.
  - write x3=0xA5 -> busy clears, data=0xA5.
- Simultaneous same address, x9 not busy: rsv_valid and wr_valid both for x9 with data 0x55 -> regs[9]=0x55, busy_mask[9]=1.
- Same-cycle read:
  - Without REGFILE_WB_BYPASS_EN: write x12=0x77 while rs1_addr=12 -> old value that cycle, 0x77 next cycle.
  - With REGFILE_WB_BYPASS_EN: 0x77 in the same cycle and rs1_busy=0.
- Reset mid-operation: hold wr_valid for x4=0xFF with reset_n=0 -> regs[4] stays 0 and busy_mask=0 after release.
